// File: rtl/reg_pipe.sv
// Parametrised valid/ready register pipeline with flush, occupancy count and
// an optional output stall counter enabled by defining REG_PIPE_STALL_CNT_EN.
module reg_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             d,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             q,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [15:0]                  stall_cnt
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] rdy;
   logic             allFull;
   logic             inFire, outFire;

   // The chained ready ~v[i] | rdy[i+1] unrolls to "out_ready, or some stage
   // from i to the end is empty"; computing it that way avoids a self-referencing vector.
   always_comb begin
      allFull = 1'b1;
      rdy     = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         allFull = allFull & v_q[i];
         rdy[i]  = out_ready | ~allFull;
      end
   end

   assign in_ready  = rst_n & ~flush & rdy[0];
   assign out_valid = v_q[DEPTH-1];
   assign q         = data_q[DEPTH-1];
   assign count     = count_q;
   assign inFire    = in_valid & in_ready;
   assign outFire   = out_valid & out_ready;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (flush) begin
         v_d = '0;
         for (int i = 0; i < DEPTH; i++) data_d[i] = RESET_VAL;
      end else begin
         if (rdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) data_d[0] = d;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               v_d[i] = v_q[i-1];
               if (v_q[i-1]) data_d[i] = data_q[i-1];
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (inFire && !outFire) begin
         count_d = count_q + CW'(1);
      end else if (!inFire && outFire) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

`ifdef REG_PIPE_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Counts edges where downstream holds off a valid word; saturates, never wraps.
   always_comb begin
      stall_d = stall_q;
      if (flush) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe (WIDTH=32, DEPTH=2); stall expectations follow
// whether REG_PIPE_STALL_CNT_EN is defined.
module tb_reg_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] d;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic             flush;
   logic [1:0]       count;
   logic [15:0]      stall_cnt;

   int          checks   = 0;
   int          failures = 0;
   int          cycle    = 0;
   logic [31:0] sb[$];
   int          outCyc[$];
   int          expStall = 0;
   bit          eeSeen   = 0;

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q),
      .flush(flush), .count(count), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Holds one word on d until it is accepted; returns the refused cycles.
   task automatic applyStimulus(input logic [31:0] word, output int waited);
      bit accepted;
      accepted = 0;
      waited   = 0;
      d        = word;
      in_valid = 1'b1;
      for (int k = 0; k < 100 && !accepted; k++) begin
         @(negedge clk);
         accepted = in_ready;
         if (!accepted) waited++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("pushTimeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      bit done;
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         if (sb.size() == 0 && !out_valid) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor samples mid-cycle: what it sees is what transfers on the next edge.
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         sb.delete();
         expStall = 0;
      end else begin
         checkOutput("count", 32'(count), 32'(sb.size()));
         checkOutput("stallCnt", 32'(stall_cnt), 32'(expStall));
         if (out_valid && out_ready) begin
            outCyc.push_back(cycle);
            if (q == 32'hEEEE_EEEE) eeSeen = 1;
            if (sb.size() == 0) checkOutput("outWhenEmpty", 32'(sb.size()), 32'd1);
            else checkOutput("qData", q, sb.pop_front());
         end
         if (in_valid && in_ready) sb.push_back(d);
         if (flush) sb.delete();
`ifdef REG_PIPE_STALL_CNT_EN
         if (flush) expStall = 0;
         else if (out_valid && !out_ready && expStall != 16'hFFFF) expStall++;
`endif
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int total;
      int base;

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      d         = 32'hFFFF_FFFF;
      out_ready = 1'b0;
      flush     = 1'b0;
      #12;
      checkOutput("rstQ", q, 32'd0);
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstInReady", 32'(in_ready), 32'd0);
      checkOutput("rstStall", 32'(stall_cnt), 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Latency: accepted at edge 0, visible after edge 1
      out_ready = 1'b1;
      d         = 32'hA5A5_A5A5;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("latEarly", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("latValid", 32'(out_valid), 32'd1);
      checkOutput("latData", q, 32'hA5A5_A5A5);
      @(posedge clk);
      #1;
      checkOutput("latCount", 32'(count), 32'd0);

      // Back-pressure
      outCyc.delete();
      out_ready = 1'b0;
      applyStimulus(32'd1, w);
      applyStimulus(32'd2, w);
      d        = 32'd3;
      in_valid = 1'b1;
      #1;
      checkOutput("bpCount", 32'(count), 32'd2);
      checkOutput("bpInReady", 32'(in_ready), 32'd0);
      checkOutput("bpQ", q, 32'd1);
      checkOutput("bpOutValid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      applyStimulus(32'd3, w);
      waitDrain();
      checkOutput("bpOutputs", 32'(outCyc.size()), 32'd3);

      // Streaming
      outCyc.delete();
      total = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'(i), w);
         total += w;
      end
      waitDrain();
      checkOutput("streamStall", 32'(total), 32'd0);
      checkOutput("streamCount", 32'(outCyc.size()), 32'd16);
      if (outCyc.size() == 16)
         checkOutput("streamSpan", 32'(outCyc[15] - outCyc[0]), 32'd15);

      // Flush with a simultaneous input
      out_ready = 1'b0;
      eeSeen    = 0;
      applyStimulus(32'd11, w);
      applyStimulus(32'd22, w);
      checkOutput("flushFull", 32'(count), 32'd2);
      flush    = 1'b1;
      in_valid = 1'b1;
      d        = 32'hEEEE_EEEE;
      #1;
      checkOutput("flushInReady", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flushCount", 32'(count), 32'd0);
      checkOutput("flushOutValid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      applyStimulus(32'd33, w);
      waitDrain();
      checkOutput("flushNoEE", 32'(eeSeen), 32'd0);

      // Stall counter
      out_ready = 1'b0;
      applyStimulus(32'd44, w);
      applyStimulus(32'd55, w);
      base = expStall;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
`ifdef REG_PIPE_STALL_CNT_EN
      checkOutput("stall5", 32'(stall_cnt), 32'(base + 5));
`else
      checkOutput("stall5", 32'(stall_cnt), 32'd0);
`endif
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("stallFlush", 32'(stall_cnt), 32'd0);
      checkOutput("stallFlushCount", 32'(count), 32'd0);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
